// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : debounce_multi
// Purpose  : N_CH independent push-button debouncers. Each channel has a
//            2-FF synchroniser, a stability-count FSM, a registered debounced
//            level and one-cycle press/release pulses.
// Options  : define LONG_PRESS_EN to build the per-channel hold counter that
//            fires a one-cycle long_press pulse after LONG_CNT held cycles.
//            Without it long_press is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_multi #(
  parameter int N_CH       = 4,
  parameter int STABLE_CNT = 3,
  parameter int LONG_CNT   = 100,
  parameter int CNT_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] input_btn,
  output logic [N_CH-1:0] output_btn,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  // Reject parameter sets whose counters could overflow or never qualify.
  generate
    if ((N_CH < 1) || (STABLE_CNT < 2) || (LONG_CNT < 1) ||
        ((64'd1 << CNT_W) <= 64'(STABLE_CNT)) || ((64'd1 << CNT_W) <= 64'(LONG_CNT))) begin : g_param_check
      $error("debounce_multi: illegal parameter combination");
    end
  endgenerate

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic             s1, s2;
      state_t           state, state_nx;
      logic [CNT_W-1:0] cnt, cnt_nx;
      logic             level, level_nx;
      logic             press_r, press_nx;
      logic             release_r, release_nx;

      // Two-flop synchroniser for the asynchronous button input.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1 <= 1'b0;
          s2 <= 1'b0;
        end else begin
          s1 <= input_btn[i];
          s2 <= s1;
        end
      end

      // FSM state, qualification counter and registered outputs.
      always_ff @(posedge clk) begin
        if (rst) begin
          state     <= IDLE;
          cnt       <= '0;
          level     <= 1'b0;
          press_r   <= 1'b0;
          release_r <= 1'b0;
        end else begin
          state     <= state_nx;
          cnt       <= cnt_nx;
          level     <= level_nx;
          press_r   <= press_nx;
          release_r <= release_nx;
        end
      end

      // Next-state logic: a change is accepted only after STABLE_CNT equal samples.
      always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        level_nx   = level;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        case (state)
          IDLE: begin
            if (s2) begin
              state_nx = PRESS_WAIT;
              cnt_nx   = CNT_ONE;
            end
          end
          PRESS_WAIT: begin
            if (!s2) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end else if (cnt == STABLE_LAST) begin
              state_nx = PRESSED;
              level_nx = 1'b1;
              press_nx = 1'b1;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
          PRESSED: begin
            if (!s2) begin
              state_nx = RELEASE_WAIT;
              cnt_nx   = CNT_ONE;
            end
          end
          RELEASE_WAIT: begin
            if (s2) begin
              state_nx = PRESSED;
              cnt_nx   = '0;
            end else if (cnt == STABLE_LAST) begin
              state_nx   = IDLE;
              level_nx   = 1'b0;
              release_nx = 1'b1;
              cnt_nx     = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
          default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        endcase
      end

      assign output_btn[i]    = level;
      assign press_pulse[i]   = press_r;
      assign release_pulse[i] = release_r;

`ifdef LONG_PRESS_EN
      localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CNT);
      localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
      logic [CNT_W-1:0] hold;
      logic             long_r;

      // Hold counter: runs while PRESSED, saturates at LONG_CNT, clears otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          hold   <= '0;
          long_r <= 1'b0;
        end else begin
          long_r <= 1'b0;
          if ((state == PRESSED) && s2) begin
            if (hold != LONG_MAX) begin
              hold   <= hold + 1'b1;
              long_r <= (hold == LONG_LAST);
            end
          end else begin
            hold <= '0;
          end
        end
      end

      assign long_press[i] = long_r;
`else
      assign long_press[i] = 1'b0;
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_multi
// Purpose  : Self-checking bench for debounce_multi. A run-length reference
//            model (accept a new level after STABLE_CNT equal synchronised
//            samples) is compared every cycle, alongside directed timing
//            checks for each scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

  localparam int N_CH       = 4;
  localparam int STABLE_CNT = 3;
  localparam int LONG_CNT   = 5;
  localparam int CNT_W      = 8;
`ifdef LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] input_btn;
  logic [N_CH-1:0] output_btn;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] long_press;

  int checks   = 0;
  int failures = 0;

  debounce_multi #(
    .N_CH(N_CH), .STABLE_CNT(STABLE_CNT), .LONG_CNT(LONG_CNT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .input_btn(input_btn), .output_btn(output_btn),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Reference model: delay the raw input two cycles, then track how long the
  // synchronised sample has disagreed with the accepted level.
  logic [N_CH-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long;
  int              m_run  [N_CH];
  int              m_hold [N_CH];

  always @(posedge clk) begin : model
    logic [N_CH-1:0] nl, np, nr, nlg;
    int              rn, hd;
    logic            x;
    if (rst) begin
      m_s1 <= '0; m_s2 <= '0; m_level <= '0;
      m_press <= '0; m_rel <= '0; m_long <= '0;
      for (int i = 0; i < N_CH; i++) begin
        m_run[i]  <= 0;
        m_hold[i] <= 0;
      end
    end else begin
      nl = m_level; np = '0; nr = '0; nlg = '0;
      for (int i = 0; i < N_CH; i++) begin
        x  = m_s2[i];
        rn = m_run[i];
        hd = m_hold[i];
        // Held pressed (accepted high, no pending release) with a high sample.
        if (m_level[i] && rn == 0 && x) begin
          if (hd < LONG_CNT) begin
            hd = hd + 1;
            if (hd == LONG_CNT) nlg[i] = LONG_EN;
          end
        end else begin
          hd = 0;
        end
        if (x != m_level[i]) begin
          rn = rn + 1;
          if (rn == STABLE_CNT) begin
            nl[i] = x;
            rn    = 0;
            if (x) np[i] = 1'b1;
            else   nr[i] = 1'b1;
          end
        end else begin
          rn = 0;
        end
        m_run[i]  <= rn;
        m_hold[i] <= hd;
      end
      m_level <= nl; m_press <= np; m_rel <= nr; m_long <= nlg;
      m_s2 <= m_s1;
      m_s1 <= input_btn;
    end
  end

  task automatic test_reset();
    int k;
    rst = 1'b1;
    input_btn = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({output_btn, press_pulse, release_pulse, long_press} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", {output_btn, press_pulse, release_pulse, long_press}, 16'h0);
    end
    rst = 1'b0;
    for (k = 1; k <= 7; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (output_btn !== ((k >= 5) ? 4'b1111 : 4'b0000)) begin
        failures++;
        $display("FAIL reset_level k=%0d got=%b exp=%b", k, output_btn, (k >= 5) ? 4'b1111 : 4'b0000);
      end
      checks++;
      if (press_pulse !== ((k == 5) ? 4'b1111 : 4'b0000)) begin
        failures++;
        $display("FAIL reset_press k=%0d got=%b exp=%b", k, press_pulse, (k == 5) ? 4'b1111 : 4'b0000);
      end
    end
    input_btn = 4'b0000;
    for (k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({output_btn, press_pulse, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        failures++;
        $display("FAIL reset_model t=%0t got=%h exp=%h", $time,
                 {output_btn, press_pulse, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
    end
  endtask

  task automatic test_clean_press();
    int press_k = -1, rel_k = -1, press_n = 0, rel_n = 0;
    for (int k = 1; k <= 20; k++) begin
      input_btn = (k <= 10) ? 4'b0001 : 4'b0000;
      @(posedge clk); @(negedge clk);
      if (press_pulse[0])   begin press_n++; press_k = k; end
      if (release_pulse[0]) begin rel_n++;   rel_k   = k; end
      checks++;
      if ({output_btn, press_pulse, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        failures++;
        $display("FAIL clean_model t=%0t got=%h exp=%h", $time,
                 {output_btn, press_pulse, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
    end
    checks++;
    if (press_k != 5 || press_n != 1) begin
      failures++;
      $display("FAIL clean_press got=cycle%0d/x%0d exp=cycle5/x1", press_k, press_n);
    end
    checks++;
    if (rel_k != 15 || rel_n != 1) begin
      failures++;
      $display("FAIL clean_release got=cycle%0d/x%0d exp=cycle15/x1", rel_k, rel_n);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat [4] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000};
    int press_k = -1, press_n = 0;
    for (int k = 1; k <= 24; k++) begin
      if (k <= 4)       input_btn = pat[k-1];
      else if (k <= 14) input_btn = 4'b0010;
      else              input_btn = 4'b0000;
      @(posedge clk); @(negedge clk);
      if (press_pulse[1]) begin press_n++; press_k = k; end
      checks++;
      if ({output_btn, press_pulse, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        failures++;
        $display("FAIL bounce_model t=%0t got=%h exp=%h", $time,
                 {output_btn, press_pulse, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
    end
    checks++;
    if (press_k != 9 || press_n != 1) begin
      failures++;
      $display("FAIL bounce_press got=cycle%0d/x%0d exp=cycle9/x1", press_k, press_n);
    end
  endtask

  task automatic test_release_bounce();
    int rel_n = 0, low_n = 0;
    input_btn = 4'b0100;
    repeat (8) begin @(posedge clk); @(negedge clk); end
    for (int k = 0; k < 12; k++) begin
      input_btn = (k % 3 == 0) ? 4'b0000 : 4'b0100;
      @(posedge clk); @(negedge clk);
      if (release_pulse[2]) rel_n++;
      if (!output_btn[2])   low_n++;
      checks++;
      if ({output_btn, press_pulse, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        failures++;
        $display("FAIL relbounce_model t=%0t got=%h exp=%h", $time,
                 {output_btn, press_pulse, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
    end
    checks++;
    if (rel_n != 0 || low_n != 0) begin
      failures++;
      $display("FAIL relbounce_hold got=rel%0d/low%0d exp=rel0/low0", rel_n, low_n);
    end
    input_btn = 4'b0000;
    repeat (8) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] seen = 4'b0000;
    int hit_k = -1;
    for (int k = 1; k <= 16; k++) begin
      input_btn = (k <= 8) ? 4'b1001 : 4'b0000;
      @(posedge clk); @(negedge clk);
      if (press_pulse != 4'b0000) begin seen = press_pulse; hit_k = k; end
      checks++;
      if ({output_btn, press_pulse, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        failures++;
        $display("FAIL simul_model t=%0t got=%h exp=%h", $time,
                 {output_btn, press_pulse, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
    end
    checks++;
    if (seen !== 4'b1001 || hit_k != 5) begin
      failures++;
      $display("FAIL simul_press got=%b@%0d exp=1001@5", seen, hit_k);
    end
  endtask

  task automatic test_long_press();
    int long_n = 0, long_k = -1;
    int exp_n = LONG_EN ? 1 : 0;
    int exp_k = LONG_EN ? 10 : -1;
    for (int k = 1; k <= 30; k++) begin
      input_btn = (k <= 20) ? 4'b0001 : 4'b0000;
      @(posedge clk); @(negedge clk);
      if (long_press[0]) begin long_n++; long_k = k; end
      checks++;
      if ({output_btn, press_pulse, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        failures++;
        $display("FAIL long_model t=%0t got=%h exp=%h", $time,
                 {output_btn, press_pulse, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
    end
    checks++;
    if (long_n != exp_n || long_k != exp_k) begin
      failures++;
      $display("FAIL long_press got=x%0d@%0d exp=x%0d@%0d", long_n, long_k, exp_n, exp_k);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(0, 4) == 0) input_btn[i] = ~input_btn[i];
      rst = ($urandom_range(0, 149) == 0);
      @(posedge clk); @(negedge clk);
      checks++;
      if ({output_btn, press_pulse, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        failures++;
        $display("FAIL random_model t=%0t got=%h exp=%h", $time,
                 {output_btn, press_pulse, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    input_btn = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_long_press();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
